// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the I/D memory-port arbiter.
// Holds the FSM encoding, owner codes and the latency-pipe entry layout.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  localparam int DEF_MEM_LAT    = 1;
  localparam int DEF_MAX_LEN    = 4;
  localparam int DEF_STARVE_LIM = 3;

  typedef struct packed {
    logic valid;
    logic owner;
    logic last;
  } pipe_ent_t;

  // Zero-length bursts read one word; oversize bursts are clamped.
  function automatic logic [2:0] norm_len(input logic [2:0] raw, input int max_len);
    logic [2:0] res;
    res = raw;
    if (raw == 3'd0) begin
      res = 3'd1;
    end else if (int'(raw) > max_len) begin
      res = 3'(max_len);
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side signals of the arbiter, bundled with
// an arbiter view (slave) and an environment view (master).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  // Handshake: REQ is a level held (with stable attributes) until DONE;
  // GNT and DONE are single-cycle pulses; RVALID qualifies RDATA per beat.
  logic              I_REQ;
  logic [ADDR_W-1:0] I_ADDR;
  logic [2:0]        I_LEN;
  logic              I_GNT;
  logic              I_RVALID;
  logic              I_DONE;

  logic              D_REQ;
  logic              D_WEN;
  logic [ADDR_W-1:0] D_ADDR;
  logic [2:0]        D_LEN;
  logic [3:0]        D_BE;
  logic [DATA_W-1:0] D_WDATA;
  logic              D_GNT;
  logic              D_RVALID;
  logic              D_DONE;

  logic [DATA_W-1:0] RDATA;

  logic              MEM_CSN;
  logic              MEM_WEN;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [3:0]        MEM_BE;
  logic [DATA_W-1:0] MEM_DOUT;
  logic [DATA_W-1:0] MEM_DI;

  modport slave (
    input  I_REQ, I_ADDR, I_LEN,
    input  D_REQ, D_WEN, D_ADDR, D_LEN, D_BE, D_WDATA,
    input  MEM_DI,
    output I_GNT, I_RVALID, I_DONE,
    output D_GNT, D_RVALID, D_DONE,
    output RDATA,
    output MEM_CSN, MEM_WEN, MEM_ADDR, MEM_BE, MEM_DOUT
  );

  modport master (
    output I_REQ, I_ADDR, I_LEN,
    output D_REQ, D_WEN, D_ADDR, D_LEN, D_BE, D_WDATA,
    output MEM_DI,
    input  I_GNT, I_RVALID, I_DONE,
    input  D_GNT, D_RVALID, D_DONE,
    input  RDATA,
    input  MEM_CSN, MEM_WEN, MEM_ADDR, MEM_BE, MEM_DOUT
  );

endinterface

// File: rtl/mem_arb_lat_pipe.sv
// Delays the per-beat {valid, owner, last} tag by the memory read latency
// so the read-valid and done strobes line up with MEM_DI.
module mem_arb_lat_pipe
  import mem_arb_pkg::*;
#(
  parameter int LAT = DEF_MEM_LAT
) (
  input  logic      CLK,
  input  logic      RST,
  input  pipe_ent_t in_ent,
  output pipe_ent_t out_ent
);

  pipe_ent_t stage_q [LAT];
  pipe_ent_t stage_d [LAT];

  always_comb begin
    stage_d[0] = in_ent;
    for (int k = 1; k < LAT; k++) begin
      stage_d[k] = stage_q[k-1];
    end
  end

  // Clearing on reset drops any beats still in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < LAT; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < LAT; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  assign out_ent = stage_q[LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and data cache (D):
// arbitrates with an I anti-starvation limit, issues bursts, returns data.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int MAX_LEN    = DEF_MAX_LEN,
  parameter int STARVE_LIM = DEF_STARVE_LIM
) (
  input  logic                 CLK,
  input  logic                 RST,
  mem_port_arbiter_if.slave    bus,
  output state_t               dbg_state
);

  localparam int SW = $clog2(STARVE_LIM + 2);

  state_t            state_q, state_d;
  logic [2:0]        beat_q, beat_d;
  logic [2:0]        len_q, len_d;
  logic [2:0]        wait_cnt_q, wait_cnt_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              owner_q, owner_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [3:0]        be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              mem_csn_q, mem_csn_d;
  logic              mem_wen_q, mem_wen_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [DATA_W-1:0] mem_dout_q, mem_dout_d;
  logic              i_gnt_q, i_gnt_d;
  logic              d_gnt_q, d_gnt_d;

  logic              i_win;
  pipe_ent_t         pipe_in;
  pipe_ent_t         pipe_out;

  // D is preferred unless I is alone or has waited out STARVE_LIM D grants.
  assign i_win = bus.I_REQ && (!bus.D_REQ || (starve_q == SW'(STARVE_LIM)));

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    len_d      = len_q;
    wait_cnt_d = wait_cnt_q;
    starve_d   = starve_q;
    owner_d    = owner_q;
    wen_d      = wen_q;
    base_d     = base_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    i_gnt_d    = 1'b0;
    d_gnt_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.I_REQ || bus.D_REQ) begin
          if (i_win) begin
            owner_d  = OWNER_I;
            base_d   = bus.I_ADDR;
            len_d    = norm_len(bus.I_LEN, MAX_LEN);
            wen_d    = 1'b1;
            be_d     = 4'hF;
            wdata_d  = '0;
            starve_d = '0;
            i_gnt_d  = 1'b1;
          end else begin
            owner_d  = OWNER_D;
            base_d   = bus.D_ADDR;
            wen_d    = bus.D_WEN;
            len_d    = bus.D_WEN ? norm_len(bus.D_LEN, MAX_LEN) : 3'd1;
            be_d     = bus.D_WEN ? 4'hF : bus.D_BE;
            wdata_d  = bus.D_WDATA;
            starve_d = bus.I_REQ ? (starve_q + SW'(1)) : '0;
            d_gnt_d  = 1'b1;
          end
          beat_d  = 3'd0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (beat_q == (len_q - 3'd1)) begin
          wait_cnt_d = 3'd0;
          state_d    = ST_WAIT;
        end else begin
          beat_d = beat_q + 3'd1;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == 3'(MEM_LAT - 1)) begin
          state_d = ST_FIN;
        end else begin
          wait_cnt_d = wait_cnt_q + 3'd1;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Memory outputs are registered, so they are built from next-cycle values.
    if (state_d == ST_ISSUE) begin
      mem_csn_d  = 1'b0;
      mem_wen_d  = wen_d;
      mem_be_d   = be_d;
      mem_addr_d = base_d + ADDR_W'(beat_d);
      mem_dout_d = wdata_d;
    end else begin
      mem_csn_d  = 1'b1;
      mem_wen_d  = 1'b1;
      mem_be_d   = 4'h0;
      mem_addr_d = '0;
      mem_dout_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      beat_q     <= '0;
      len_q      <= '0;
      wait_cnt_q <= '0;
      starve_q   <= '0;
      owner_q    <= OWNER_I;
      wen_q      <= 1'b1;
      base_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      mem_csn_q  <= 1'b1;
      mem_wen_q  <= 1'b1;
      mem_addr_q <= '0;
      mem_be_q   <= '0;
      mem_dout_q <= '0;
      i_gnt_q    <= 1'b0;
      d_gnt_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      len_q      <= len_d;
      wait_cnt_q <= wait_cnt_d;
      starve_q   <= starve_d;
      owner_q    <= owner_d;
      wen_q      <= wen_d;
      base_q     <= base_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      mem_csn_q  <= mem_csn_d;
      mem_wen_q  <= mem_wen_d;
      mem_addr_q <= mem_addr_d;
      mem_be_q   <= mem_be_d;
      mem_dout_q <= mem_dout_d;
      i_gnt_q    <= i_gnt_d;
      d_gnt_q    <= d_gnt_d;
    end
  end

  // Tag each visible address cycle; beat_q is aligned with the address shown.
  assign pipe_in = '{
    valid: !mem_csn_q && mem_wen_q,
    owner: owner_q,
    last:  !mem_csn_q && (beat_q == (len_q - 3'd1))
  };

  mem_arb_lat_pipe #(
    .LAT (MEM_LAT)
  ) u_lat_pipe (
    .CLK     (CLK),
    .RST     (RST),
    .in_ent  (pipe_in),
    .out_ent (pipe_out)
  );

  assign bus.I_GNT    = i_gnt_q;
  assign bus.D_GNT    = d_gnt_q;
  assign bus.I_RVALID = pipe_out.valid && (pipe_out.owner == OWNER_I);
  assign bus.D_RVALID = pipe_out.valid && (pipe_out.owner == OWNER_D);
  assign bus.I_DONE   = pipe_out.last  && (pipe_out.owner == OWNER_I);
  assign bus.D_DONE   = pipe_out.last  && (pipe_out.owner == OWNER_D);
  assign bus.RDATA    = bus.MEM_DI;

  assign bus.MEM_CSN  = mem_csn_q;
  assign bus.MEM_WEN  = mem_wen_q;
  assign bus.MEM_ADDR = mem_addr_q;
  assign bus.MEM_BE   = mem_be_q;
  assign bus.MEM_DOUT = mem_dout_q;

  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random and directed traffic on both requesters, checked by a scoreboard
// fed from a transaction-level reference model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int TB_LAT = 1;
  localparam int MAXL   = 4;
  localparam int SLIM   = 3;

  logic clk;
  logic rst;
  state_t dbg_state;
  int cyc = 0;

  mem_port_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W(12), .DATA_W(32), .MEM_LAT(TB_LAT), .MAX_LEN(MAXL), .STARVE_LIM(SLIM)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- external memory emulation ----------------
  logic [31:0] sim_mem [4096];
  logic [31:0] ref_mem [4096];
  logic [31:0] rd_pipe [TB_LAT];
  logic [31:0] seed;
  logic        mem_init;

  function automatic logic [31:0] seed_val(input int k);
    return (32'(k) * 32'h9E3779B1) ^ seed;
  endfunction

  always @(posedge clk) begin
    for (int k = TB_LAT - 1; k > 0; k--) rd_pipe[k] <= rd_pipe[k-1];
    rd_pipe[0] <= (!bus.MEM_CSN && bus.MEM_WEN) ? sim_mem[bus.MEM_ADDR] : 32'h0;
    if (mem_init) begin
      for (int k = 0; k < 4096; k++) sim_mem[k] <= seed_val(k);
    end else if (!bus.MEM_CSN && !bus.MEM_WEN) begin
      for (int b = 0; b < 4; b++)
        if (bus.MEM_BE[b]) sim_mem[bus.MEM_ADDR][8*b +: 8] <= bus.MEM_DOUT[8*b +: 8];
    end
  end
  assign bus.MEM_DI = rd_pipe[TB_LAT-1];

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [33:0] gnt_exp_q [$];
  logic [80:0] bus_exp_q [$];
  logic [65:0] rv_exp_q  [$];
  logic [33:0] done_exp_q[$];
  logic        gnt_log   [$];
  logic        mon_en = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string nm, input logic [127:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got unexpected event %h expected none (cycle %0d)", nm, act, cyc);
  endtask

  // Monitor: pops an expectation whenever the DUT presents an event.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (bus.I_GNT || bus.D_GNT) begin
        gnt_log.push_back(bus.D_GNT);
        if (gnt_exp_q.size() == 0) unexpected("gnt", {32'(cyc), bus.I_GNT, bus.D_GNT});
        else chk("gnt", 128'({32'(cyc), bus.I_GNT, bus.D_GNT}), 128'(gnt_exp_q.pop_front()));
      end
      if (!bus.MEM_CSN) begin
        if (bus_exp_q.size() == 0) unexpected("mem_bus", {32'(cyc), bus.MEM_ADDR});
        else chk("mem_bus", 128'({32'(cyc), bus.MEM_ADDR, bus.MEM_WEN, bus.MEM_BE,
                                  bus.MEM_WEN ? 32'h0 : bus.MEM_DOUT}),
                 128'(bus_exp_q.pop_front()));
      end
      if (bus.I_RVALID || bus.D_RVALID) begin
        if (rv_exp_q.size() == 0) unexpected("rvalid", {32'(cyc), bus.I_RVALID, bus.D_RVALID});
        else chk("rvalid", 128'({32'(cyc), bus.I_RVALID, bus.D_RVALID, bus.RDATA}),
                 128'(rv_exp_q.pop_front()));
      end
      if (bus.I_DONE || bus.D_DONE) begin
        if (done_exp_q.size() == 0) unexpected("done", {32'(cyc), bus.I_DONE, bus.D_DONE});
        else chk("done", 128'({32'(cyc), bus.I_DONE, bus.D_DONE}), 128'(done_exp_q.pop_front()));
      end
    end
  end

  // ---------------- reference model ----------------
  int m_free = 0;
  int m_starve = 0;

  function automatic int eff_len(input logic [2:0] l);
    if (l == 3'd0) return 1;
    if (int'(l) > MAXL) return MAXL;
    return int'(l);
  endfunction

  // Called once per cycle with that cycle's final requester inputs.
  task automatic model_step();
    int a, len;
    bit iw;
    logic [11:0] base, addr;
    logic wen;
    logic [3:0] be;
    logic [31:0] wd;
    if (rst || cyc < m_free || !(bus.I_REQ || bus.D_REQ)) return;
    a  = cyc;
    iw = bus.I_REQ && (!bus.D_REQ || m_starve == SLIM);
    if (iw) begin
      m_starve = 0;
      base = bus.I_ADDR; len = eff_len(bus.I_LEN); wen = 1'b1; be = 4'hF; wd = 32'h0;
    end else begin
      m_starve = bus.I_REQ ? m_starve + 1 : 0;
      base = bus.D_ADDR; wen = bus.D_WEN;
      len  = wen ? eff_len(bus.D_LEN) : 1;
      be   = wen ? 4'hF : bus.D_BE;
      wd   = bus.D_WDATA;
    end
    gnt_exp_q.push_back({32'(a + 1), iw, !iw});
    for (int k = 0; k < len; k++) begin
      addr = base + 12'(k);
      bus_exp_q.push_back({32'(a + 1 + k), addr, wen, be, wen ? 32'h0 : wd});
      if (wen) rv_exp_q.push_back({32'(a + 1 + k + TB_LAT), iw, !iw, ref_mem[addr]});
    end
    if (!wen)
      for (int b = 0; b < 4; b++) if (be[b]) ref_mem[base][8*b +: 8] = wd[8*b +: 8];
    done_exp_q.push_back({32'(a + len + TB_LAT), iw, !iw});
    m_free = a + len + TB_LAT + 2;
  endtask

  // ---------------- drivers ----------------
  bit auto_i = 0, auto_d = 0;
  int p_i = 0, p_d = 0;

  function automatic logic [11:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 12'hFFC + 12'($urandom_range(0, 3));
    return 12'($urandom_range(0, 4095));
  endfunction

  task automatic new_i();
    bus.I_ADDR = rand_addr();
    bus.I_LEN  = 3'($urandom_range(0, 7));
    bus.I_REQ  = 1'b1;
  endtask

  task automatic new_d();
    bus.D_WEN   = 1'($urandom_range(0, 1));
    bus.D_ADDR  = rand_addr();
    bus.D_LEN   = 3'($urandom_range(0, 7));
    bus.D_BE    = 4'($urandom_range(0, 15));
    bus.D_WDATA = $urandom;
    bus.D_REQ   = 1'b1;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk); #1;
    if (bus.I_DONE) bus.I_REQ = 1'b0;
    if (bus.D_DONE) bus.D_REQ = 1'b0;
    if (auto_i && !bus.I_REQ && $urandom_range(0, 99) < p_i) new_i();
    if (auto_d && !bus.D_REQ && $urandom_range(0, 99) < p_d) new_d();
  endtask

  task automatic drain();
    int t;
    auto_i = 0; auto_d = 0;
    t = 0;
    while ((bus.I_REQ || bus.D_REQ) && t < 300) begin tick(); t++; end
    chk("drain_reqs_released", 128'({bus.I_REQ, bus.D_REQ}), 128'(0));
    repeat (3) tick();
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_csn"}, 128'(bus.MEM_CSN), 128'(1));
    chk({tag, "_strobes"}, 128'({bus.I_GNT, bus.D_GNT, bus.I_RVALID, bus.D_RVALID,
                                  bus.I_DONE, bus.D_DONE}), 128'(0));
    chk({tag, "_addr_be"}, 128'({bus.MEM_ADDR, bus.MEM_BE}), 128'(0));
    chk({tag, "_state"}, 128'(dbg_state), 128'(ST_IDLE));
  endtask

  task automatic flush_model();
    gnt_exp_q.delete(); bus_exp_q.delete(); rv_exp_q.delete(); done_exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  bit exp_order [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  int beats;

  initial begin
    rst = 1'b1;
    bus.I_REQ = 0; bus.I_ADDR = '0; bus.I_LEN = '0;
    bus.D_REQ = 0; bus.D_WEN = 1; bus.D_ADDR = '0; bus.D_LEN = '0; bus.D_BE = '0; bus.D_WDATA = '0;
    seed = $urandom;
    for (int k = 0; k < 4096; k++) ref_mem[k] = seed_val(k);
    mem_init = 1'b1;
    repeat (3) tick();
    mem_init = 1'b0;
    check_idle("reset");
    rst = 1'b0;
    m_free = cyc; m_starve = 0;
    mon_en = 1'b1;

    // I-only single read
    bus.I_ADDR = 12'h010; bus.I_LEN = 3'd1; bus.I_REQ = 1'b1;
    drain();

    // D read burst wrapping the top of the address space
    bus.D_WEN = 1'b1; bus.D_ADDR = 12'hFFE; bus.D_LEN = 3'd4; bus.D_REQ = 1'b1;
    drain();

    // D write: length ignored, single word with partial byte enables
    bus.D_WEN = 1'b0; bus.D_ADDR = 12'h123; bus.D_LEN = 3'd3; bus.D_BE = 4'b0011;
    bus.D_WDATA = 32'hDEADBEEF; bus.D_REQ = 1'b1;
    drain();

    // Read back the written word
    bus.I_ADDR = 12'h123; bus.I_LEN = 3'd0; bus.I_REQ = 1'b1;
    drain();

    // Continuous contention from both sides
    gnt_log.delete();
    auto_i = 1; auto_d = 1; p_i = 100; p_d = 100;
    new_i(); new_d();
    repeat (80) tick();
    drain();
    chk("contention_grant_count_ge8", 128'(gnt_log.size() >= 8), 128'(1));
    for (int k = 0; k < 8; k++)
      if (k < gnt_log.size()) chk($sformatf("grant_order_%0d", k), 128'(gnt_log[k]), 128'(exp_order[k]));

    // Reset during beat 2 of a 4-beat read
    bus.D_WEN = 1'b1; bus.D_ADDR = 12'h200; bus.D_LEN = 3'd4; bus.D_REQ = 1'b1;
    beats = 0;
    for (int t = 0; t < 50 && beats < 2; t++) begin
      tick();
      if (!bus.MEM_CSN) beats++;
    end
    chk("abort_reached_beat2", 128'(beats), 128'(2));
    rst = 1'b1;
    bus.D_REQ = 1'b0;
    flush_model();
    tick();
    check_idle("abort");
    rst = 1'b0;
    m_free = cyc; m_starve = 0;
    repeat (8) tick();

    // Randomized traffic with varying request intensity
    for (int blk = 0; blk < 4; blk++) begin
      auto_i = 1; auto_d = 1;
      p_i = $urandom_range(10, 100);
      p_d = $urandom_range(10, 100);
      repeat (500) tick();
    end
    drain();

    chk("gnt_q_left",  128'(gnt_exp_q.size()),  128'(0));
    chk("bus_q_left",  128'(bus_exp_q.size()),  128'(0));
    chk("rv_q_left",   128'(rv_exp_q.size()),   128'(0));
    chk("done_q_left", 128'(done_exp_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
